tx_frame_arbiter: RTL and testbench

Shares the single serial `transmitting` engine between two byte producers (CPU port and echo/status port). It accepts 8-bit characters over per-requester req/ack handshakes and frames each as a 10-bit start/data/stop word. It loads the transmitter via `load_n`, holds `enable` for the duration of the character and waits for `charSent`. It enforces an inter-character gap and flags a stalled transmitter. It sits directly in front of `transmitting` in the serial output path.

---
 rtl/tx_arb_pkg.sv | 21 ++
 rtl/tx_rr_picker.sv | 33 +++
 rtl/tx_frame_arbiter.sv | 102 ++++++++++
 tb/tb_tx_frame_arbiter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/tx_arb_pkg.sv
// Shared types and constants for the two-requester transmit frame arbiter.
package tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_SENT = 2'd2,
    GAP       = 2'd3
  } arb_state_t;

  localparam int unsigned FRAME_W   = 10;
  localparam logic        START_BIT = 1'b0;
  localparam logic        STOP_BIT  = 1'b1;
  localparam logic [FRAME_W-1:0] IDLE_LINE = 10'h3FF;

  // Bit 0 leaves the transmitter first, so the start bit sits in the LSB.
  function automatic logic [FRAME_W-1:0] build_frame(input logic [7:0] data);
    return {STOP_BIT, data, START_BIT};
  endfunction

endpackage

// File: rtl/tx_rr_picker.sv
// Winner select for two requesters; round-robin when TX_ARB_RR_EN is defined,
// fixed priority to requester 0 otherwise.
module tx_rr_picker
  import tx_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic       winner
);

  logic prio;

  always_comb begin
    winner = 1'b0;
    if (req == 2'b11) winner = prio;
    else if (req[1])  winner = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio <= 1'b0;
    end else if (update) begin
`ifdef TX_ARB_RR_EN
      prio <= ~winner;
`else
      prio <= 1'b0;
`endif
    end
  end

endmodule

// File: rtl/tx_frame_arbiter.sv
// Arbitrates two byte producers onto one serial transmitter, framing each
// character and enforcing an idle gap; TX_ARB_RR_EN selects round-robin.
module tx_frame_arbiter
  import tx_arb_pkg::*;
#(
  parameter int unsigned GAP_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         req,
  input  logic [7:0]         data0,
  input  logic [7:0]         data1,
  output logic [1:0]         ack,
  output logic               grant_id,
  output logic               busy,
  output logic               timeout_err,
  output logic [FRAME_W-1:0] tx_data_in,
  output logic               tx_load_n,
  output logic               tx_enable,
  input  logic               tx_char_sent
);

  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(GAP_CYCLES - 1);

  arb_state_t       state, state_next;
  logic [TO_W-1:0]  to_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             winner;
  logic             start;

  assign start = (state == IDLE) && (|req);

  tx_rr_picker u_picker (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .update (start),
    .winner (winner)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    ack        = '0;
    tx_load_n  = 1'b1;
    tx_enable  = 1'b0;
    busy       = (state != IDLE);
    unique case (state)
      IDLE: if (|req) state_next = LOAD;
      LOAD: begin
        tx_load_n     = 1'b0;
        tx_enable     = 1'b1;
        ack[grant_id] = 1'b1;
        state_next    = WAIT_SENT;
      end
      WAIT_SENT: begin
        tx_enable = 1'b1;
        if (tx_char_sent || to_cnt == TO_MAX) state_next = GAP;
      end
      GAP: if (gap_cnt == GAP_MAX) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_id    <= 1'b0;
      tx_data_in  <= IDLE_LINE;
      to_cnt      <= '0;
      gap_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          grant_id   <= winner;
          tx_data_in <= build_frame(winner ? data1 : data0);
        end
        LOAD: to_cnt <= '0;
        WAIT_SENT: begin
          if (to_cnt != TO_MAX) to_cnt <= to_cnt + 1'b1;
          // A done arriving on the final count wins over the timeout.
          if (!tx_char_sent && to_cnt == TO_MAX) timeout_err <= 1'b1;
          if (state_next == GAP) begin
            tx_data_in <= IDLE_LINE;
            gap_cnt    <= '0;
          end
        end
        GAP: if (gap_cnt != GAP_MAX) gap_cnt <= gap_cnt + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Directed self-checking bench for tx_frame_arbiter (expectations follow TX_ARB_RR_EN).
module tb_tx_frame_arbiter;

  localparam int GAP = 16;
  localparam int TMO = 256;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] req = 2'b00;
  logic [7:0] data0 = 8'h00, data1 = 8'h00;
  logic [1:0] ack;
  logic       grant_id, busy, timeout_err, tx_load_n, tx_enable;
  logic       tx_char_sent = 1'b0;
  logic [9:0] tx_data_in;

  int tests = 0;
  int fails = 0;

  tx_frame_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .req(req), .data0(data0), .data1(data1),
    .ack(ack), .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err),
    .tx_data_in(tx_data_in), .tx_load_n(tx_load_n), .tx_enable(tx_enable),
    .tx_char_sent(tx_char_sent)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = 2'b00; tx_char_sent = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  // From WAIT_SENT: signal done, then run out the gap back to IDLE.
  task automatic finish_char();
    tx_char_sent = 1'b1; tick(); tx_char_sent = 1'b0;
    for (int i = 0; i < GAP; i++) tick();
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (ack !== 2'b00) begin fails++; $display("FAIL reset_ack: got %b expected 00", ack); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests++; if (tx_data_in !== 10'h3FF) begin fails++; $display("FAIL reset_frame: got %h expected 3ff", tx_data_in); end
    tests++; if ({tx_load_n, tx_enable, grant_id, timeout_err} !== 4'b1000) begin
      fails++; $display("FAIL reset_ctl: got %b expected 1000", {tx_load_n, tx_enable, grant_id, timeout_err}); end
  endtask

  task automatic test_single();
    do_reset();
    data0 = 8'hA5; req = 2'b01;
    tick();
    req = 2'b00;
    tests++; if (ack !== 2'b01) begin fails++; $display("FAIL single_ack: got %b expected 01", ack); end
    tests++; if ({tx_load_n, tx_enable, busy} !== 3'b011) begin
      fails++; $display("FAIL single_load: got %b expected 011", {tx_load_n, tx_enable, busy}); end
    tests++; if (tx_data_in !== 10'b1101001010) begin fails++; $display("FAIL single_frame: got %b expected 1101001010", tx_data_in); end
    tick();
    tests++; if ({ack, tx_load_n, tx_enable} !== 4'b0011) begin
      fails++; $display("FAIL single_wait: got %b expected 0011", {ack, tx_load_n, tx_enable}); end
    for (int i = 0; i < 20; i++) tick();
    tx_char_sent = 1'b1; tick(); tx_char_sent = 1'b0;
    tests++; if ({tx_enable, busy, tx_data_in} !== {2'b01, 10'h3FF}) begin
      fails++; $display("FAIL single_gap: got %b/%b/%h expected 0/1/3ff", tx_enable, busy, tx_data_in); end
    for (int i = 0; i < GAP - 1; i++) tick();
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_gap_end: got %b expected 1", busy); end
    tick();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_idle: got %b expected 0", busy); end
  endtask

  task automatic test_contention();
    logic [2:0] exp_gid;
`ifdef TX_ARB_RR_EN
    exp_gid = 3'b010;
`else
    exp_gid = 3'b000;
`endif
    do_reset();
    data0 = 8'h41; data1 = 8'h42; req = 2'b11;
    for (int n = 0; n < 3; n++) begin
      tick();
      tests++; if (grant_id !== exp_gid[n]) begin
        fails++; $display("FAIL contend_gid%0d: got %b expected %b", n, grant_id, exp_gid[n]); end
      tests++; if (ack !== (exp_gid[n] ? 2'b10 : 2'b01)) begin
        fails++; $display("FAIL contend_ack%0d: got %b expected %b", n, ack, exp_gid[n] ? 2'b10 : 2'b01); end
      tests++; if (tx_data_in !== (exp_gid[n] ? 10'b1010000100 : 10'b1010000010)) begin
        fails++; $display("FAIL contend_frame%0d: got %b", n, tx_data_in); end
      tick();
      finish_char();
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL contend_idle%0d: got %b expected 0", n, busy); end
    end
    req = 2'b00;
  endtask

  task automatic test_stale_sent();
    do_reset();
    data0 = 8'h00; req = 2'b01;
    tick();
    req = 2'b00; tx_char_sent = 1'b1;
    tick();
    tx_char_sent = 1'b0;
    for (int i = 0; i < 159; i++) tick();
    tests++; if ({tx_enable, tx_load_n, busy, tx_data_in} !== {3'b111, 10'b1000000000}) begin
      fails++; $display("FAIL stale_wait: got %b/%b/%b/%b expected 1/1/1/1000000000", tx_enable, tx_load_n, busy, tx_data_in); end
    tx_char_sent = 1'b1; tick(); tx_char_sent = 1'b0;
    tests++; if ({tx_enable, busy, timeout_err} !== 3'b010) begin
      fails++; $display("FAIL stale_gap: got %b expected 010", {tx_enable, busy, timeout_err}); end
    for (int i = 0; i < GAP; i++) tick();
  endtask

  task automatic test_sent_at_timeout();
    do_reset();
    data0 = 8'h11; req = 2'b01;
    tick(); req = 2'b00; tick();
    for (int i = 0; i < TMO - 1; i++) tick();
    tx_char_sent = 1'b1; tick(); tx_char_sent = 1'b0;
    tests++; if ({tx_enable, busy, timeout_err} !== 3'b010) begin
      fails++; $display("FAIL tie_no_err: got %b expected 010", {tx_enable, busy, timeout_err}); end
    for (int i = 0; i < GAP; i++) tick();
  endtask

  task automatic test_timeout();
    do_reset();
    data0 = 8'h5A; req = 2'b01;
    tick(); req = 2'b00; tick();
    for (int i = 0; i < TMO - 1; i++) tick();
    tests++; if ({tx_enable, timeout_err} !== 2'b10) begin
      fails++; $display("FAIL tmo_before: got %b expected 10", {tx_enable, timeout_err}); end
    tick();
    tests++; if ({tx_enable, busy, timeout_err} !== 3'b011) begin
      fails++; $display("FAIL tmo_set: got %b expected 011", {tx_enable, busy, timeout_err}); end
    for (int i = 0; i < GAP; i++) tick();
    tests++; if ({busy, timeout_err} !== 2'b01) begin
      fails++; $display("FAIL tmo_idle: got %b expected 01", {busy, timeout_err}); end
    data1 = 8'h3C; req = 2'b10;
    tick(); req = 2'b00;
    tests++; if ({ack, grant_id, tx_data_in} !== {2'b10, 1'b1, 10'b1001111000}) begin
      fails++; $display("FAIL tmo_next: got %b/%b/%b expected 10/1/1001111000", ack, grant_id, tx_data_in); end
    tick();
    finish_char();
    tests++; if ({busy, timeout_err} !== 2'b01) begin
      fails++; $display("FAIL tmo_sticky: got %b expected 01", {busy, timeout_err}); end
  endtask

  // Runs straight after test_timeout so timeout_err is still set on entry.
  task automatic test_reset_mid();
    data1 = 8'h77; req = 2'b10;
    tick(); req = 2'b00; tick();
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    tests++; if ({tx_enable, tx_load_n, busy, timeout_err, grant_id} !== 5'b01000) begin
      fails++; $display("FAIL rst_mid: got %b expected 01000", {tx_enable, tx_load_n, busy, timeout_err, grant_id}); end
    tests++; if ({ack, tx_data_in} !== {2'b00, 10'h3FF}) begin
      fails++; $display("FAIL rst_mid_frame: got %b/%h expected 00/3ff", ack, tx_data_in); end
    data0 = 8'h01; req = 2'b01;
    tick(); req = 2'b00;
    reset = 1'b1; tick(); reset = 1'b0;
    tests++; if ({ack, busy, tx_load_n} !== 4'b0001) begin
      fails++; $display("FAIL rst_load: got %b expected 0001", {ack, busy, tx_load_n}); end
  endtask

  task automatic test_drop_req();
    do_reset();
    data1 = 8'hC3; req = 2'b10;
    tick();
    req = 2'b00; data1 = 8'h00;
    tests++; if ({ack, tx_load_n} !== 3'b100) begin
      fails++; $display("FAIL drop_ack: got %b expected 100", {ack, tx_load_n}); end
    tests++; if (tx_data_in !== 10'b1110000110) begin
      fails++; $display("FAIL drop_frame: got %b expected 1110000110", tx_data_in); end
    tick();
    tests++; if ({ack, tx_enable, busy} !== 4'b0011) begin
      fails++; $display("FAIL drop_wait: got %b expected 0011", {ack, tx_enable, busy}); end
    finish_char();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_stale_sent();
    test_sent_at_timeout();
    test_timeout();
    test_reset_mid();
    test_drop_req();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
